// File: rtl/serial_adder_arb.sv
// Bit-serial adder shared by two requesters through a round-robin arbiter.
// Optional subtract mode is enabled by defining SERIAL_ADDER_ARB_SUB_EN.
module serial_adder_arb #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
`ifdef SERIAL_ADDER_ARB_SUB_EN
    input  logic             req0_sub,
    input  logic             req1_sub,
`endif
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_carry,
    output logic             res_id,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               carry_q, carry_d;
    logic [CNT_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               res_carry_q, res_carry_d;
    logic               res_id_q, res_id_d;
    logic               last_grant_q, last_grant_d;

    logic               grant_s;
    logic               any_valid_s;
    logic               sub_s;
    logic               a_bit_s;
    logic               b_bit_s;
    logic               s_bit_s;
    logic               maj_s;

    // Round-robin winner selection; the requester not granted last time wins a tie
    always_comb begin
        grant_s     = 1'b0;
        any_valid_s = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_q;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
`ifdef SERIAL_ADDER_ARB_SUB_EN
        sub_s = grant_s ? req1_sub : req0_sub;
`else
        sub_s = 1'b0;
`endif
    end

    // Select the operand bits at the current index and form sum and carry
    always_comb begin
        a_bit_s = 1'b0;
        b_bit_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            a_bit_s = a_bit_s | (a_q[i] & (idx_q == CNT_W'(i)));
            b_bit_s = b_bit_s | (b_q[i] & (idx_q == CNT_W'(i)));
        end
        s_bit_s = a_bit_s ^ b_bit_s ^ carry_q;
        maj_s   = (a_bit_s & b_bit_s) | (a_bit_s & carry_q) | (b_bit_s & carry_q);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake and status decoded from the state register
    always_comb begin
        req0_ready = (state_q == IDLE) & req0_valid & ~grant_s;
        req1_ready = (state_q == IDLE) & req1_valid & grant_s;
        res_valid  = (state_q == DONE);
        busy       = (state_q != IDLE);
    end

    // Datapath next values: operand latch on accept, one bit per RUN cycle
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        carry_d      = carry_q;
        idx_d        = idx_q;
        sum_d        = sum_q;
        res_carry_d  = res_carry_q;
        res_id_d     = res_id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (any_valid_s) begin
                    a_d          = grant_s ? req1_a : req0_a;
                    // Subtract is a + ~b + 1: invert b here, seed the carry with 1
                    b_d          = (grant_s ? req1_b : req0_b) ^ {WIDTH{sub_s}};
                    carry_d      = sub_s;
                    idx_d        = {CNT_W{1'b0}};
                    sum_d        = {WIDTH{1'b0}};
                    res_carry_d  = 1'b0;
                    res_id_d     = grant_s;
                    last_grant_d = grant_s;
                end else begin
                    a_d = a_q;
                end
            end
            RUN: begin
                carry_d = maj_s;
                idx_d   = idx_q + CNT_W'(1);
                for (int i = 0; i < WIDTH; i++) begin
                    sum_d[i] = (idx_q == CNT_W'(i)) ? s_bit_s : sum_q[i];
                end
                if (idx_q == LAST_IDX) begin
                    res_carry_d = maj_s;
                end else begin
                    res_carry_d = res_carry_q;
                end
            end
            DONE: begin
                sum_d = sum_q;
            end
            default: begin
                sum_d = sum_q;
            end
        endcase
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q          <= {WIDTH{1'b0}};
            b_q          <= {WIDTH{1'b0}};
            carry_q      <= 1'b0;
            idx_q        <= {CNT_W{1'b0}};
            sum_q        <= {WIDTH{1'b0}};
            res_carry_q  <= 1'b0;
            res_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            carry_q      <= carry_d;
            idx_q        <= idx_d;
            sum_q        <= sum_d;
            res_carry_q  <= res_carry_d;
            res_id_q     <= res_id_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign res_sum   = sum_q;
    assign res_carry = res_carry_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_serial_adder_arb.sv
// Scoreboard bench for serial_adder_arb (WIDTH=4); subtract vectors run only
// when SERIAL_ADDER_ARB_SUB_EN is defined.
module tb_serial_adder_arb;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req0_valid, req1_valid, req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         res_valid, res_ready, res_carry, res_id, busy;
    logic [W-1:0] res_sum;
`ifdef SERIAL_ADDER_ARB_SUB_EN
    logic         req0_sub, req1_sub;
`endif

    // Expected entry: {id, carry, sum}
    logic [5:0] exp_q[$];
    logic [5:0] mon_e;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    serial_adder_arb #(.WIDTH(W), .CNT_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
`ifdef SERIAL_ADDER_ARB_SUB_EN
        .req0_sub(req0_sub), .req1_sub(req1_sub),
`endif
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_carry(res_carry), .res_id(res_id), .busy(busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Monitor: every result handshake pops and checks one scoreboard entry
    always @(negedge clk) begin
        if (rst_n && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got sum %0h id %0h expected none", res_sum, res_id);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_sum", 32'(res_sum), 32'(mon_e[3:0]));
                chk("res_carry", 32'(res_carry), 32'(mon_e[4]));
                chk("res_id", 32'(res_id), 32'(mon_e[5]));
            end
        end
    end

    task automatic issue(input logic id, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] es, input logic ec, input logic sub);
        int n;
        logic rdy;
        if (id == 1'b0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end
`ifdef SERIAL_ADDER_ARB_SUB_EN
        if (id == 1'b0) req0_sub = sub; else req1_sub = sub;
`else
        if (sub) $display("note: subtract vector ignored in add-only build");
`endif
        n = 0;
        do begin
            @(negedge clk);
            n++;
            rdy = id ? req1_ready : req0_ready;
        end while (!rdy && n < 200);
        chk("accept_seen", 32'(rdy), 32'd1);
        if (rdy) exp_q.push_back({id, ec, es});
        @(posedge clk);
        #1;
        // Scramble operands after the accept edge; the result must not change
        if (id == 1'b0) begin
            req0_valid = 1'b0; req0_a = ~a; req0_b = ~b;
        end else begin
            req1_valid = 1'b0; req1_a = ~a; req1_b = ~b;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'h0; req0_b = 4'h0; req1_a = 4'h0; req1_b = 4'h0;
        res_ready = 1'b1;
`ifdef SERIAL_ADDER_ARB_SUB_EN
        req0_sub = 1'b0; req1_sub = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_sum", 32'(res_sum), 32'd0);
        chk("rst_res_carry", 32'(res_carry), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 5+3: ready for one cycle, res_valid on the 5th edge after accept
        req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h3;
        @(negedge clk);
        chk("lat_ready0", 32'(req0_ready), 32'd1);
        chk("lat_ready1", 32'(req1_ready), 32'd0);
        exp_q.push_back({1'b0, 1'b0, 4'h8});
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("lat_ready0_one_cycle", 32'(req0_ready), 32'd0);
        chk("lat_busy_run", 32'(busy), 32'd1);
        chk("lat_valid_e1", 32'(res_valid), 32'd0);
        req0_valid = 1'b0; req0_a = 4'hF; req0_b = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat_valid_low", 32'(res_valid), 32'd0);
        end
        @(negedge clk);
        chk("lat_valid_high", 32'(res_valid), 32'd1);
        drain();

        issue(1'b0, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0);
        issue(1'b1, 4'hF, 4'hF, 4'hE, 1'b1, 1'b0);
        drain();

        // Contention: last grant was 1, so grants go 0,1,0,1
        req0_valid = 1'b1; req0_a = 4'h1; req0_b = 4'h2;
        req1_valid = 1'b1; req1_a = 4'h9; req1_b = 4'h8;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back((k % 2 == 0) ? {1'b0, 1'b0, 4'h3} : {1'b1, 1'b1, 4'h1});
        end
        for (int k = 0; k < 4; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(req0_ready || req1_ready) && n < 100);
            chk("rr_grant", 32'({req1_ready, req0_ready}), (k % 2 == 0) ? 32'd1 : 32'd2);
            @(posedge clk);
            #1;
            if (k == 3) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        drain();

        // DONE held with res_ready low while req1 waits
        res_ready = 1'b0;
        issue(1'b0, 4'h6, 4'h7, 4'hD, 1'b0, 1'b0);
        fork
            issue(1'b1, 4'hA, 4'h5, 4'hF, 1'b0, 1'b0);
            begin
                n = 0;
                do begin
                    @(negedge clk);
                    n++;
                end while (!res_valid && n < 50);
                chk("hold_valid", 32'(res_valid), 32'd1);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("hold_valid_stable", 32'(res_valid), 32'd1);
                    chk("hold_sum_stable", 32'(res_sum), 32'hD);
                    chk("hold_id_stable", 32'(res_id), 32'd0);
                    chk("hold_req1_ready", 32'(req1_ready), 32'd0);
                end
                @(posedge clk);
                #1;
                res_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("post_hs_req1_ready", 32'(req1_ready), 32'd1);
            end
        join
        drain();

        // Reset pulsed in the 2nd RUN cycle of a requester-0 operation
        req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h4;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!req0_ready && n < 50);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_busy", 32'(busy), 32'd0);
        chk("midrun_rst_valid", 32'(res_valid), 32'd0);
        chk("midrun_rst_sum", 32'(res_sum), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h2;
        req1_valid = 1'b1; req1_a = 4'h1; req1_b = 4'h1;
        exp_q.push_back({1'b0, 1'b0, 4'h4});
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(req0_ready || req1_ready) && n < 50);
        chk("post_rst_grant", 32'({req1_ready, req0_ready}), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

`ifdef SERIAL_ADDER_ARB_SUB_EN
        issue(1'b0, 4'h3, 4'h5, 4'hE, 1'b0, 1'b1);
        issue(1'b1, 4'h7, 4'h2, 4'h5, 1'b1, 1'b1);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder_arb.md
Name: serial_adder_arb

Overview:
- Shares one 1-bit full-adder datapath between two requesters.
- Performs WIDTH-bit additions bit-serially, LSB first, with a registered carry.
- Round-robin arbiter picks a requester; FSM sequences WIDTH single-bit add steps; result is held with a valid/ready handshake.
- Area-minimal arithmetic service for small benchmark designs that cannot afford a full-width adder per client.

Parameters:
WIDTH, 4, operand width in bits; legal range 1..32
CNT_W, 5, bit-index counter width; must satisfy 2**CNT_W > WIDTH

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operation pending
req0_a  input  WIDTH  requester 0 operand a
req0_b  input  WIDTH  requester 0 operand b
req0_ready  output  1  requester 0 operands accepted this cycle
req1_valid  input  1  requester 1 has an operation pending
req1_a  input  WIDTH  requester 1 operand a
req1_b  input  WIDTH  requester 1 operand b
req1_ready  output  1  requester 1 operands accepted this cycle
res_valid  output  1  result available
res_ready  input  1  consumer takes result
res_sum  output  WIDTH  sum bits
res_carry  output  1  carry out of MSB
res_id  output  1  requester that owns the result
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all outputs 0; internal carry=0; bit index=0.
  - last_grant=1, so requester 0 wins the first contention.
- IDLE:
  - reqN_ready is combinational; high only for the winner, and only while in IDLE with reqN_valid=1.
  - Winner selection:
    - one valid: that requester wins;
    - both valid: the requester != last_grant wins;
    - none valid: stay in IDLE.
  - On the accept edge:
    - latch a and b;
    - set res_id and last_grant to the winner;
    - carry=0, index=0, res_sum=0;
    - go to RUN.
- RUN, one bit per cycle at index i:
  - s = a[i]^b[i]^carry;
  - carry <= majority(a[i], b[i], carry);
  - res_sum[i] <= s;
  - index increments.
  - When i == WIDTH-1: res_carry <= new carry, go to DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE:
  - res_valid=1; res_sum, res_carry and res_id are stable.
  - On res_valid&res_ready go to IDLE. The next accept can occur in the cycle after that handshake; IDLE lasts at least one cycle.
- Latency:
  - res_valid rises WIDTH+1 edges after the accept edge: accept edge, then WIDTH RUN edges.
  - res_valid is high on the cycle after the final RUN edge.
- Arithmetic: {res_carry, res_sum} == a + b, computed modulo 2**(WIDTH+1) with no truncation.
- Boundaries:
  - reqN_valid dropping while not granted: no effect, nothing latched.
  - Input operand changes after the accept edge do not affect the result.
  - res_ready held high in DONE: result consumed in its first valid cycle.
  - WIDTH=1: a single RUN cycle.
  - Reset asserted mid-RUN or mid-DONE:
    - immediate return to IDLE; the pending result is discarded;
    - res_valid drops asynchronously;
    - last_grant returns to 1.
  - busy=0 exactly when state==IDLE.

Optional Feature:
- Macro: SERIAL_ADDER_ARB_SUB_EN
- Defined:
  - adds ports req0_sub and req1_sub (input, 1 bit), latched on the accept edge;
  - when sub=1: b is inverted bitwise at latch and carry initialises to 1, so res_sum = a - b mod 2**WIDTH;
  - res_carry = 1 means no borrow (a >= b).
- Undefined: the sub ports do not exist; addition only; carry initialises to 0.

Test Plan:
- Reset, then req0 a=4'h5, b=4'h3 -> req0_ready for one cycle; res_valid after 5 edges; res_sum=4'h8, res_carry=0, res_id=0.
- Single request a=4'hF, b=4'h1 -> res_sum=4'h0, res_carry=1. Then a=4'hF, b=4'hF -> res_sum=4'hE, res_carry=1.
- Both requesters valid continuously, res_ready=1 -> grants alternate 0,1,0,1; each request served once per cycle gap; no requester is starved.
- DONE with res_ready=0 for 3 cycles, req1 valid -> result held stable, req1_ready stays 0; release res_ready -> req1 accepted in the following IDLE cycle.
- rst_n pulsed low during the 2nd RUN cycle -> outputs 0 immediately; after release, requester 0 wins contention again; the next result is correct.
- With SERIAL_ADDER_ARB_SUB_EN: sub=1, a=4'h3, b=4'h5 -> res_sum=4'hE, res_carry=0. Then sub=1, a=4'h7, b=4'h2 -> res_sum=4'h5, res_carry=1.
